// File: rtl/mano_control_core_if.sv
// Core-side bus for mano_control_core: run control, RAM port and architectural state.
interface mano_control_core_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = ADDR_W + 4
);
  logic              run;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ac;
  logic              e;
  logic [7:0]        sc_t;
  logic              instr_done;
  logic              halted;

  modport master (
    input  run, mem_rdata,
    output mem_addr, mem_wdata, mem_we, pc, ac, e, sc_t, instr_done, halted
  );

  modport slave (
    output run, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, pc, ac, e, sc_t, instr_done, halted
  );
endinterface

// File: rtl/mano_control_core.sv
// Mano basic-computer registers plus hard-wired control unit (T0..T6 sequencing).
// Define MANO_INDIRECT_EN to enable the T3 indirect address fetch for opcodes 0-6.
module mano_control_core #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = ADDR_W + 4
) (
  input logic                 CLK,
  input logic                 RST,
  mano_control_core_if.master bus
);
  localparam int unsigned SUM_W = DATA_W + 1;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  // One-hot encoding so the state register is the sc_t timing output itself
  typedef enum logic [7:0] {
    T0 = 8'h01, T1 = 8'h02, T2 = 8'h04, T3 = 8'h08,
    T4 = 8'h10, T5 = 8'h20, T6 = 8'h40
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, ar, ar_nxt;
  logic [DATA_W-1:0] ir, ir_nxt, dr, dr_nxt, ac, ac_nxt, wdata, wdata_nxt;
  logic              e, e_nxt, ind, ind_nxt, halted, halted_nxt;
  logic              we, we_nxt, done, done_nxt;
  logic [2:0]        op;
  logic [ADDR_W-1:0] b;
  logic [DATA_W-1:0] rr_ac;
  logic              rr_e;

  assign op = ir[DATA_W-2:DATA_W-4];
  assign b  = ir[ADDR_W-1:0];

  // Next-state and registered-output decode; write strobe and done are set one cycle ahead
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ar_nxt     = ar;
    ir_nxt     = ir;
    dr_nxt     = dr;
    ac_nxt     = ac;
    e_nxt      = e;
    ind_nxt    = ind;
    halted_nxt = halted;
    we_nxt     = 1'b0;
    wdata_nxt  = '0;
    done_nxt   = 1'b0;
    rr_ac      = ac;
    rr_e       = e;

    // Register-reference micro-ops applied in order CLA, CMA, CIR, CIL
    if (b[ADDR_W-1]) rr_ac = '0;
    if (b[ADDR_W-2]) rr_ac = ~rr_ac;
    if (b[ADDR_W-3]) {rr_ac, rr_e} = {rr_e, rr_ac};
    if (b[ADDR_W-4]) {rr_e, rr_ac} = {rr_ac, rr_e};

    unique case (state)
      T0: begin
        if (bus.run && !halted) begin
          ar_nxt    = pc;
          state_nxt = T1;
        end
      end
      T1: begin
        ir_nxt    = bus.mem_rdata;
        pc_nxt    = pc + ADDR_W'(1);
        state_nxt = T2;
      end
      T2: begin
        ar_nxt    = ir[ADDR_W-1:0];
        ind_nxt   = ir[DATA_W-1];
        done_nxt  = (op == OP_REG);
        state_nxt = T3;
      end
      T3: begin
        if (op == OP_REG) begin
          if (ind) begin
            halted_nxt = 1'b1;
          end else begin
            ac_nxt = rr_ac;
            e_nxt  = rr_e;
          end
          state_nxt = T0;
        end else begin
`ifdef MANO_INDIRECT_EN
          if (ind) ar_nxt = bus.mem_rdata[ADDR_W-1:0];
`endif
          case (op)
            OP_STA: begin
              we_nxt    = 1'b1;
              wdata_nxt = ac;
              done_nxt  = 1'b1;
            end
            OP_BSA: begin
              we_nxt    = 1'b1;
              wdata_nxt = DATA_W'(pc);
            end
            OP_BUN:  done_nxt = 1'b1;
            default: ;
          endcase
          state_nxt = T4;
        end
      end
      T4: begin
        state_nxt = T5;
        case (op)
          OP_AND, OP_ADD, OP_LDA: begin
            dr_nxt   = bus.mem_rdata;
            done_nxt = 1'b1;
          end
          OP_ISZ: dr_nxt = bus.mem_rdata;
          OP_BSA: begin
            ar_nxt   = ar + ADDR_W'(1);
            done_nxt = 1'b1;
          end
          OP_BUN: begin
            pc_nxt    = ar;
            state_nxt = T0;
          end
          default: state_nxt = T0;
        endcase
      end
      T5: begin
        state_nxt = T0;
        case (op)
          OP_AND: ac_nxt = ac & dr;
          OP_ADD: {e_nxt, ac_nxt} = SUM_W'(ac) + SUM_W'(dr);
          OP_LDA: ac_nxt = dr;
          OP_BSA: pc_nxt = ar;
          OP_ISZ: begin
            dr_nxt    = dr + DATA_W'(1);
            we_nxt    = 1'b1;
            wdata_nxt = dr + DATA_W'(1);
            done_nxt  = 1'b1;
            state_nxt = T6;
          end
          default: ;
        endcase
      end
      T6: begin
        if (dr == '0) pc_nxt = pc + ADDR_W'(1);
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= T0;
      pc     <= '0;
      ar     <= '0;
      ir     <= '0;
      dr     <= '0;
      ac     <= '0;
      e      <= 1'b0;
      ind    <= 1'b0;
      halted <= 1'b0;
      we     <= 1'b0;
      wdata  <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      ar     <= ar_nxt;
      ir     <= ir_nxt;
      dr     <= dr_nxt;
      ac     <= ac_nxt;
      e      <= e_nxt;
      ind    <= ind_nxt;
      halted <= halted_nxt;
      we     <= we_nxt;
      wdata  <= wdata_nxt;
      done   <= done_nxt;
    end
  end

  assign bus.mem_addr   = ar;
  assign bus.mem_wdata  = wdata;
  assign bus.mem_we     = we;
  assign bus.pc         = pc;
  assign bus.ac         = ac;
  assign bus.e          = e;
  assign bus.sc_t       = state;
  assign bus.instr_done = done;
  assign bus.halted     = halted;
endmodule

// File: tb/tb_mano_control_core.sv
// Bench for mano_control_core: program table, pause/reset sequences and random
// programs checked instruction by instruction against an ISA-level model.
`timescale 1ns/1ps
module tb_mano_control_core;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned MEM_N  = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ld  = 1'b0;

  mano_control_core_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mano_control_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  // Async-read RAM; img is copied in whole on a load cycle
  logic [7:0] mem [MEM_N];
  logic [7:0] img [MEM_N];
  int we_cnt = 0;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge CLK) begin
    if (ld) mem <= img;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_we) we_cnt <= we_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Load img, pulse reset, release it with the core sitting in T0
  task automatic start(input logic run_v);
    RST = 1'b1;
    bus.run = run_v;
    ld = 1'b1;
    @(posedge CLK); #1;
    ld = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic clear_img();
    for (int j = 0; j < int'(MEM_N); j++) img[j] = 8'h00;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!bus.halted && cyc < 300) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  // ---------------- ISA-level reference model ----------------
  logic [7:0] mm [MEM_N];
  logic [7:0] m_ac;
  logic       m_e;
  logic [3:0] m_pc;
  logic       m_halt;
  int         m_wr;

  task automatic model_step(output int lat);
    logic [7:0] w;
    logic [2:0] op;
    logic [3:0] a;
    logic [8:0] v;
    w = mm[m_pc];
    op = w[6:4];
    a = w[3:0];
    m_pc = m_pc + 4'd1;
    lat = 6;
    if (op == 3'd7) begin
      lat = 4;
      if (w[7]) m_halt = 1'b1;
      else begin
        if (w[3]) m_ac = 8'h00;
        if (w[2]) m_ac = ~m_ac;
        v = {m_e, m_ac};
        if (w[1]) v = {v[0], v[8:1]};
        if (w[0]) v = {v[7:0], v[8]};
        m_e = v[8];
        m_ac = v[7:0];
      end
    end else begin
`ifdef MANO_INDIRECT_EN
      if (w[7]) a = mm[a][3:0];
`endif
      case (op)
        3'd0: m_ac = m_ac & mm[a];
        3'd1: begin
          v = 9'(m_ac) + 9'(mm[a]);
          m_e = v[8];
          m_ac = v[7:0];
        end
        3'd2: m_ac = mm[a];
        3'd3: begin mm[a] = m_ac; m_wr++; lat = 5; end
        3'd4: begin m_pc = a; lat = 5; end
        3'd5: begin mm[a] = {4'h0, m_pc}; m_pc = a + 4'd1; m_wr++; end
        default: begin
          mm[a] = mm[a] + 8'd1;
          if (mm[a] == 8'd0) m_pc = m_pc + 4'd1;
          m_wr++;
          lat = 7;
        end
      endcase
    end
  endtask

  // ---------------- program table ----------------
  typedef struct {
    string      name;
    logic [7:0] w0, w1, w2, w3;
    logic [3:0] da0; logic [7:0] dv0;
    logic [3:0] da1; logic [7:0] dv1;
    logic [7:0] exp_ac; logic exp_e; logic [3:0] exp_pc;
    logic [3:0] chk_a; logic [7:0] chk_v;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int cyc, lat, cnt, base;
    logic [7:0] ind_ac;
`ifdef MANO_INDIRECT_EN
    ind_ac = 8'h3C;
`else
    ind_ac = 8'h0B;
`endif
    vecs[0]  = '{"lda_add_sta", 8'h2A, 8'h1B, 8'h3C, 8'hF0, 4'hA, 8'h05, 4'hB, 8'h07, 8'h0C, 1'b0, 4'h4, 4'hC, 8'h0C, 21};
    vecs[1]  = '{"add_carry",   8'h2A, 8'h1B, 8'hF0, 8'h00, 4'hA, 8'hF0, 4'hB, 8'h20, 8'h10, 1'b1, 4'h3, 4'hA, 8'hF0, 16};
    vecs[2]  = '{"bsa",         8'h58, 8'h00, 8'h00, 8'h00, 4'h9, 8'hF0, 4'h9, 8'hF0, 8'h00, 1'b0, 4'hA, 4'h8, 8'h01, 10};
    vecs[3]  = '{"isz_skip",    8'h65, 8'h2A, 8'hF0, 8'h00, 4'h5, 8'hFF, 4'hA, 8'h77, 8'h00, 1'b0, 4'h3, 4'h5, 8'h00, 11};
    vecs[4]  = '{"isz_noskip",  8'h65, 8'hF0, 8'h00, 8'h00, 4'h5, 8'h03, 4'h5, 8'h03, 8'h00, 1'b0, 4'h2, 4'h5, 8'h04, 11};
    vecs[5]  = '{"cla_cir",     8'h2A, 8'h7A, 8'hF0, 8'h00, 4'hA, 8'h81, 4'hA, 8'h81, 8'h00, 1'b0, 4'h3, 4'hA, 8'h81, 14};
    vecs[6]  = '{"cil",         8'h2A, 8'h71, 8'hF0, 8'h00, 4'hA, 8'h81, 4'hA, 8'h81, 8'h02, 1'b1, 4'h3, 4'hA, 8'h81, 14};
    vecs[7]  = '{"cma_cir",     8'h2A, 8'h76, 8'hF0, 8'h00, 4'hA, 8'h81, 4'hA, 8'h81, 8'h3F, 1'b0, 4'h3, 4'hA, 8'h81, 14};
    vecs[8]  = '{"bun",         8'h4C, 8'h00, 8'h00, 8'h00, 4'hC, 8'hF0, 4'hC, 8'hF0, 8'h00, 1'b0, 4'hD, 4'hC, 8'hF0, 9};
    vecs[9]  = '{"and_sta",     8'h2A, 8'h0B, 8'h3E, 8'hF0, 4'hA, 8'hF3, 4'hB, 8'h3C, 8'h30, 1'b0, 4'h4, 4'hE, 8'h30, 21};
    vecs[10] = '{"indirect",    8'hAA, 8'hF0, 8'h00, 8'h00, 4'hA, 8'h0B, 4'hB, 8'h3C, ind_ac, 1'b0, 4'h2, 4'hB, 8'h3C, 10};
    vecs[11] = '{"pc_wrap",     8'h4F, 8'h00, 8'h00, 8'h00, 4'hF, 8'hF0, 4'hF, 8'hF0, 8'h00, 1'b0, 4'h0, 4'hF, 8'hF0, 9};

    // Reset state while RST is held
    bus.run = 1'b0;
    clear_img();
    start(1'b0);
    RST = 1'b1;
    #1;
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_ac", 32'(bus.ac), 32'h0);
    check("rst_e", 32'(bus.e), 32'h0);
    check("rst_sc_t", 32'(bus.sc_t), 32'h01);
    check("rst_we", 32'(bus.mem_we), 32'h0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_done", 32'(bus.instr_done), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_addr", 32'(bus.mem_addr), 32'h0);

    foreach (vecs[k]) begin
      clear_img();
      img[0] = vecs[k].w0; img[1] = vecs[k].w1; img[2] = vecs[k].w2; img[3] = vecs[k].w3;
      img[vecs[k].da0] = vecs[k].dv0;
      img[vecs[k].da1] = vecs[k].dv1;
      start(1'b1);
      run_to_halt(cyc);
      check({vecs[k].name, "_cycles"}, 32'(cyc), 32'(vecs[k].exp_cyc));
      check({vecs[k].name, "_ac"}, 32'(bus.ac), 32'(vecs[k].exp_ac));
      check({vecs[k].name, "_e"}, 32'(bus.e), 32'(vecs[k].exp_e));
      check({vecs[k].name, "_pc"}, 32'(bus.pc), 32'(vecs[k].exp_pc));
      check({vecs[k].name, "_mem"}, 32'(mem[vecs[k].chk_a]), 32'(vecs[k].chk_v));
    end

    // Timing walk through LDA, then pause STA with run dropped in T2
    clear_img();
    img[0] = 8'h2A; img[1] = 8'h3C; img[2] = 8'hF0; img[4'hA] = 8'h55;
    start(1'b1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("lda_sc_t%0d", i), 32'(bus.sc_t), 32'(8'h01 << i));
      check($sformatf("lda_done%0d", i), 32'(bus.instr_done), 32'(i == 5));
      check($sformatf("lda_we%0d", i), 32'(bus.mem_we), 32'h0);
      @(posedge CLK); #1;
    end
    check("lda_ac", 32'(bus.ac), 32'h55);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pause_at_t2", 32'(bus.sc_t), 32'h04);
    bus.run = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pause_sta_we", 32'(bus.mem_we), 32'h1);
    check("pause_sta_wdata", 32'(bus.mem_wdata), 32'h55);
    check("pause_sta_done", 32'(bus.instr_done), 32'h1);
    for (int i = 0; i < 4; i++) begin @(posedge CLK); #1; end
    check("pause_parked", 32'(bus.sc_t), 32'h01);
    check("pause_pc", 32'(bus.pc), 32'h2);
    check("pause_mem", 32'(mem[4'hC]), 32'h55);
    bus.run = 1'b1;
    run_to_halt(cyc);
    check("resume_hlt_cycles", 32'(cyc), 32'd4);
    base = we_cnt;
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge CLK); #1; end
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) begin @(posedge CLK); #1; end
    check("halt_sticky", 32'(bus.halted), 32'h1);
    check("halt_sc_t", 32'(bus.sc_t), 32'h01);
    check("halt_pc", 32'(bus.pc), 32'h3);
    check("halt_no_we", 32'(we_cnt - base), 32'h0);

    // Reset asserted during STA-T4 aborts the write
    clear_img();
    img[0] = 8'h3C; img[4'hC] = 8'h99;
    start(1'b1);
    for (int i = 0; i < 4; i++) begin @(posedge CLK); #1; end
    check("abort_at_t4", 32'(bus.sc_t), 32'h10);
    check("abort_we_before", 32'(bus.mem_we), 32'h1);
    RST = 1'b1;
    #1;
    check("abort_we", 32'(bus.mem_we), 32'h0);
    check("abort_pc", 32'(bus.pc), 32'h0);
    check("abort_sc_t", 32'(bus.sc_t), 32'h01);
    @(posedge CLK); #1;
    bus.run = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;
    check("abort_mem", 32'(mem[4'hC]), 32'h99);

    // Random programs, checked after every instruction
    for (int r = 0; r < 40; r++) begin
      for (int j = 0; j < int'(MEM_N); j++) begin
        img[j] = 8'($urandom);
        mm[j] = img[j];
      end
      m_ac = 8'h00; m_e = 1'b0; m_pc = 4'h0; m_halt = 1'b0; m_wr = 0;
      start(1'b1);
      base = we_cnt;
      for (int n = 0; n < 12 && !m_halt; n++) begin
        cnt = 0;
        while (1) begin
          cnt++;
          if (bus.instr_done || cnt > 12) break;
          @(posedge CLK); #1;
        end
        model_step(lat);
        check($sformatf("rnd%0d_i%0d_lat", r, n), 32'(cnt), 32'(lat));
        @(posedge CLK); #1;
        check($sformatf("rnd%0d_i%0d_ac", r, n), 32'(bus.ac), 32'(m_ac));
        check($sformatf("rnd%0d_i%0d_e", r, n), 32'(bus.e), 32'(m_e));
        check($sformatf("rnd%0d_i%0d_pc", r, n), 32'(bus.pc), 32'(m_pc));
        check($sformatf("rnd%0d_i%0d_halt", r, n), 32'(bus.halted), 32'(m_halt));
      end
      check($sformatf("rnd%0d_writes", r), 32'(we_cnt - base), 32'(m_wr));
      for (int j = 0; j < int'(MEM_N); j++)
        check($sformatf("rnd%0d_mem%0d", r, j), 32'(mem[j]), 32'(mm[j]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule

// File: doc/mano_control_core.md
# mano_control_core

Parametrised, synthesizable Mano basic-computer core: sequence counter, PC, AR, IR, DR, AC and E flip-flop plus the hard-wired control unit that today lives as bench-side stimulus. Executes the full memory-reference set (AND, ADD, LDA, STA, BUN, BSA, ISZ), register-reference AC operations and HLT against an external async-read RAM. Sits between the system top level and `RAM`. It replaces the per-register glue around `sequence_counter`, `PC_program_counter`, `AR_address_register`, `AC_accumulator` and `DR_data_register`.

## Interface
- `ADDR_W`, 4 — address/PC/AR width; instruction address field width.
- `DATA_W`, ADDR_W+4 — word width; must equal ADDR_W+4. Instruction layout: [DATA_W-1]=I, [DATA_W-2:DATA_W-4]=opcode, [ADDR_W-1:0]=B/address.
- `CLK` in 1 — single clock, all state on rising edge.
- `RST` in 1 — asynchronous, active-high reset.
- `run` in 1 — 1: fetch proceeds; 0: core holds at T0 (instruction boundary).
- `mem_addr` out ADDR_W — always equals AR.
- `mem_rdata` in DATA_W — RAM read data, combinational from `mem_addr`.
- `mem_wdata` out DATA_W — write data (AC, PC zero-extended, or DR).
- `mem_we` out 1 — write strobe, RAM writes on the rising edge while high.
- `pc` out ADDR_W, `ac` out DATA_W, `e` out 1 — architectural state.
- `sc_t` out 8 — one-hot timing T0..T7 (T7 unused).
- `instr_done` out 1 — one-cycle pulse in the last cycle of each instruction.
- `halted` out 1 — sticky halt flag.

## Operation
- Reset values: PC=0, AR=0, IR=0, DR=0, AC=0, E=0, I=0, sc_t=8'h01, mem_we=0, mem_wdata=0, instr_done=0, halted=0.
- T0: if run=1 and halted=0: AR<=PC, SC->T1; else hold T0.
- T1: IR<=mem_rdata, PC<=PC+1 (wraps modulo 2^ADDR_W).
- T2: AR<=IR[ADDR_W-1:0], I<=IR msb, decode opcode.
- T3, opcode 7, I=0 (register-ref): apply set B bits in order CLA(B[ADDR_W-1]), CMA(B[ADDR_W-2]), CIR(B[ADDR_W-3]), CIL(B[ADDR_W-4]). CIR/CIL rotate through E. Then SC->T0.
- T3, opcode 7, I=1: HLT; halted<=1, SC->T0.
- T3, opcode 0–6: if I=1, AR<=mem_rdata[ADDR_W-1:0]; otherwise no-op.
- T4: AND/ADD/LDA/ISZ: DR<=mem_rdata. STA: mem_we=1, mem_wdata=AC, SC->T0. BUN: PC<=AR, SC->T0. BSA: mem_we=1, mem_wdata=PC, AR<=AR+1.
- T5: AND AC<=AC&DR; ADD {E,AC}<=AC+DR (carry-out to E); LDA AC<=DR; each SC->T0. BSA: PC<=AR, SC->T0. ISZ: DR<=DR+1.
- T6 (ISZ): mem_we=1, mem_wdata=DR; if DR==0, PC<=PC+1; SC->T0.
- Arithmetic is modulo 2^DATA_W. AR+1 and PC+1 wrap to 0.
- Halted: SC holds T0, no memory writes, run ignored. Only RST clears it.

## Timing
- Latency from T0 to instr_done: register-ref/HLT 4 cycles; STA/BUN 5; AND/ADD/LDA/BSA 6; ISZ 7.
- instr_done is high in the cycle whose edge returns SC to T0.
- mem_we is asserted only in STA-T4, BSA-T4 and ISZ-T6, for exactly one cycle each.
- run is sampled only in T0. Deasserting it mid-instruction completes that instruction, then parks the core.
- RST mid-instruction aborts immediately: mem_we drops asynchronously and all state takes its reset values.

## Configuration
- `MANO_INDIRECT_EN` defined: I=1 on opcodes 0–6 performs the T3 indirect fetch.
- Not defined: I is ignored for opcodes 0–6, T3 is a no-op, and timing is unchanged. HLT decoding is unaffected.

## Test plan
All scenarios use defaults (ADDR_W=4, DATA_W=8).
- Load/add/store: M[0..3]=2A,1B,3C,F0; M[A]=05, M[B]=07; RST then run=1 -> M[C]=0C, ac=0C, e=0, halted=1 after 6+6+5+4 cycles.
- ADD carry: ac=F0, DR operand 20 -> ac=10, e=1.
- Indirect (macro on): M[0]=AA (LDA I A), M[A]=0B, M[B]=3C -> ac=3C. Macro off: the same program gives ac=0B.
- BSA/ISZ: M[0]=58 -> M[8]=01, pc=9. ISZ with M[5]=FF: M[0]=65 -> M[5]=00, pc=2, instr_done at cycle 7.
- Register-ref: ac=81, e=0, IR=7A (CLA+CIR) -> ac=00. IR=71 (CIL) on ac=81 -> ac=02, e=1.
- Pause/reset: run=0 during T2 -> instruction completes and SC parks at T0. RST asserted at STA-T4 -> mem_we=0 immediately, pc=0, sc_t=01.
